// File: rtl/rs_age_select.sv
// Reservation station: CDB wakeup, credit-gated ISSUE_W-stage select; RS_AGE_ORDER_EN = oldest-first, else lowest index.
// Issue is same-cycle combinational from registered state plus CDB; dispatch is backpressured by disp_stall.
module rs_age_select #(
   parameter int RS_DEPTH  = 16,
   parameter int DISP_W    = 3,
   parameter int ISSUE_W   = 3,
   parameter int CDB_W     = 3,
   parameter int PR_W      = 6,
   parameter int PAYLOAD_W = 64
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic                          flush,
   input  logic [DISP_W-1:0]             disp_valid,
   input  logic [DISP_W*2-1:0]           disp_fu,
   input  logic [DISP_W*PR_W-1:0]        disp_dest_pr,
   input  logic [DISP_W*PR_W-1:0]        disp_src1_pr,
   input  logic [DISP_W*PR_W-1:0]        disp_src2_pr,
   input  logic [DISP_W-1:0]             disp_src1_rdy,
   input  logic [DISP_W-1:0]             disp_src2_rdy,
   input  logic [DISP_W*PAYLOAD_W-1:0]   disp_payload,
   output logic [DISP_W-1:0]             disp_stall,
   input  logic [CDB_W-1:0]              cdb_valid,
   input  logic [CDB_W*PR_W-1:0]         cdb_tag,
   input  logic [7:0]                    fu_credit,
   output logic [ISSUE_W-1:0]            iss_valid,
   output logic [ISSUE_W*2-1:0]          iss_fu,
   output logic [ISSUE_W*PR_W-1:0]       iss_dest_pr,
   output logic [ISSUE_W*PR_W-1:0]       iss_src1_pr,
   output logic [ISSUE_W*PR_W-1:0]       iss_src2_pr,
   output logic [ISSUE_W*PAYLOAD_W-1:0]  iss_payload,
   output logic [$clog2(RS_DEPTH):0]     free_count
);

   localparam int IDX_W = $clog2(RS_DEPTH);
   localparam int FC_W  = IDX_W + 1;

   logic [RS_DEPTH-1:0]  valid, src1_rdy, src2_rdy;
   logic [1:0]           fu_q    [RS_DEPTH];
   logic [PR_W-1:0]      dest_q  [RS_DEPTH];
   logic [PR_W-1:0]      src1_q  [RS_DEPTH];
   logic [PR_W-1:0]      src2_q  [RS_DEPTH];
   logic [PAYLOAD_W-1:0] pay_q   [RS_DEPTH];

   logic [RS_DEPTH-1:0]  rdy1_nx, rdy2_nx, elig, taken;
   logic [IDX_W-1:0]     slot [DISP_W];
   logic [DISP_W-1:0]    accept;

`ifdef RS_AGE_ORDER_EN
   // age_q[e][j] set means entry e is younger than entry j
   logic [RS_DEPTH-1:0]  age_q  [RS_DEPTH];
   logic [RS_DEPTH-1:0]  age_nx [RS_DEPTH];
`endif

   function automatic logic woken(input logic [PR_W-1:0] t);
      woken = 1'b0;
      for (int c = 0; c < CDB_W; c++)
         if (cdb_valid[c] && cdb_tag[c*PR_W +: PR_W] == t) woken = 1'b1;
   endfunction

   always_comb begin : wakeup
      for (int e = 0; e < RS_DEPTH; e++) begin
         rdy1_nx[e] = src1_rdy[e] | woken(src1_q[e]);
         rdy2_nx[e] = src2_rdy[e] | woken(src2_q[e]);
         elig[e]    = valid[e] & rdy1_nx[e] & rdy2_nx[e];
      end
   end

   always_comb begin : count_free
      free_count = '0;
      for (int e = 0; e < RS_DEPTH; e++)
         free_count = free_count + FC_W'(!valid[e]);
   end

   always_comb begin : dispatch_ctl
      int n;
      n = 0;
      for (int i = 0; i < DISP_W; i++) slot[i] = '0;
      for (int e = 0; e < RS_DEPTH; e++) begin
         if (!valid[e] && n < DISP_W) begin
            slot[n] = IDX_W'(e);
            n = n + 1;
         end
      end
      for (int i = 0; i < DISP_W; i++) begin
         disp_stall[i] = (free_count <= FC_W'(i)) | flush;
         accept[i]     = disp_valid[i] & ~disp_stall[i];
      end
   end

   always_comb begin : select
      logic [1:0]          cred [4];
      logic [RS_DEPTH-1:0] cand;
      logic [RS_DEPTH-1:0] older;
      logic                found;
      logic [IDX_W-1:0]    pick;
      taken       = '0;
      iss_valid   = '0;
      iss_fu      = '0;
      iss_dest_pr = '0;
      iss_src1_pr = '0;
      iss_src2_pr = '0;
      iss_payload = '0;
      for (int c = 0; c < 4; c++) cred[c] = fu_credit[2*c +: 2];
      for (int s = 0; s < ISSUE_W; s++) begin
         cand = elig & ~taken;
         for (int e = 0; e < RS_DEPTH; e++)
            if (cred[fu_q[e]] == 2'd0) cand[e] = 1'b0;
         found = 1'b0;
         pick  = '0;
         for (int e = 0; e < RS_DEPTH; e++) begin
`ifdef RS_AGE_ORDER_EN
            older = age_q[e] & cand;
`else
            older = '0;
`endif
            if (!found && cand[e] && older == '0) begin
               found = 1'b1;
               pick  = IDX_W'(e);
            end
         end
         if (found && !flush) begin
            taken[pick]                   = 1'b1;
            cred[fu_q[pick]]              = cred[fu_q[pick]] - 2'd1;
            iss_valid[s]                  = 1'b1;
            iss_fu[2*s +: 2]              = fu_q[pick];
            iss_dest_pr[s*PR_W +: PR_W]   = dest_q[pick];
            iss_src1_pr[s*PR_W +: PR_W]   = src1_q[pick];
            iss_src2_pr[s*PR_W +: PR_W]   = src2_q[pick];
            iss_payload[s*PAYLOAD_W +: PAYLOAD_W] = pay_q[pick];
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         valid    <= '0;
         src1_rdy <= '0;
         src2_rdy <= '0;
      end else if (flush) begin
         valid <= '0;
      end else begin
         valid    <= valid & ~taken;
         src1_rdy <= rdy1_nx;
         src2_rdy <= rdy2_nx;
         for (int i = 0; i < DISP_W; i++) begin
            if (accept[i]) begin
               valid[slot[i]]    <= 1'b1;
               src1_rdy[slot[i]] <= disp_src1_rdy[i] | woken(disp_src1_pr[i*PR_W +: PR_W]);
               src2_rdy[slot[i]] <= disp_src2_rdy[i] | woken(disp_src2_pr[i*PR_W +: PR_W]);
            end
         end
      end
   end

   // Datapath fields are only meaningful while valid is set.
   always_ff @(posedge clock) begin
      for (int i = 0; i < DISP_W; i++) begin
         if (accept[i]) begin
            fu_q[slot[i]]   <= disp_fu[2*i +: 2];
            dest_q[slot[i]] <= disp_dest_pr[i*PR_W +: PR_W];
            src1_q[slot[i]] <= disp_src1_pr[i*PR_W +: PR_W];
            src2_q[slot[i]] <= disp_src2_pr[i*PR_W +: PR_W];
            pay_q[slot[i]]  <= disp_payload[i*PAYLOAD_W +: PAYLOAD_W];
         end
      end
   end

`ifdef RS_AGE_ORDER_EN
   always_comb begin : age_update
      age_nx = age_q;
      for (int i = 0; i < DISP_W; i++)
         if (accept[i])
            for (int j = 0; j < RS_DEPTH; j++) age_nx[j][slot[i]] = 1'b0;
      for (int i = 0; i < DISP_W; i++) begin
         if (accept[i]) begin
            age_nx[slot[i]] = valid;
            for (int m = 0; m < i; m++)
               if (accept[m]) age_nx[slot[i]][slot[m]] = 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int e = 0; e < RS_DEPTH; e++) age_q[e] <= '0;
      end else begin
         age_q <= age_nx;
      end
   end
`endif

endmodule

// File: tb/tb_rs_age_select.sv
// Randomized and directed bench for rs_age_select against a sequence-number reservation-station model.
module tb_rs_age_select;
   localparam int D = 16, DW = 3, IW = 3, CW = 3, PW = 6, PLW = 64;

   logic              clock = 1'b0;
   logic              reset_n = 1'b1;
   logic              flush;
   logic [DW-1:0]     disp_valid, disp_src1_rdy, disp_src2_rdy, disp_stall;
   logic [DW*2-1:0]   disp_fu;
   logic [DW*PW-1:0]  disp_dest_pr, disp_src1_pr, disp_src2_pr;
   logic [DW*PLW-1:0] disp_payload;
   logic [CW-1:0]     cdb_valid;
   logic [CW*PW-1:0]  cdb_tag;
   logic [7:0]        fu_credit;
   logic [IW-1:0]     iss_valid;
   logic [IW*2-1:0]   iss_fu;
   logic [IW*PW-1:0]  iss_dest_pr, iss_src1_pr, iss_src2_pr;
   logic [IW*PLW-1:0] iss_payload;
   logic [4:0]        free_count;

   rs_age_select #(.RS_DEPTH(D), .DISP_W(DW), .ISSUE_W(IW), .CDB_W(CW), .PR_W(PW), .PAYLOAD_W(PLW)) dut (
      .clock(clock), .reset_n(reset_n), .flush(flush),
      .disp_valid(disp_valid), .disp_fu(disp_fu), .disp_dest_pr(disp_dest_pr),
      .disp_src1_pr(disp_src1_pr), .disp_src2_pr(disp_src2_pr),
      .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
      .disp_payload(disp_payload), .disp_stall(disp_stall),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .fu_credit(fu_credit),
      .iss_valid(iss_valid), .iss_fu(iss_fu), .iss_dest_pr(iss_dest_pr),
      .iss_src1_pr(iss_src1_pr), .iss_src2_pr(iss_src2_pr), .iss_payload(iss_payload),
      .free_count(free_count));

   always #5 clock = ~clock;

   int n_chk = 0;
   int n_pass = 0;

   // Model: each entry remembers its dispatch sequence number for age.
   bit        m_v  [D];
   bit [1:0]  m_fu [D];
   bit [5:0]  m_d  [D], m_s1 [D], m_s2 [D];
   bit        m_r1 [D], m_r2 [D];
   bit [63:0] m_p  [D];
   int        m_seq [D];
   int        seq_ctr = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   task automatic idle();
      flush = 0; disp_valid = '0; disp_fu = '0; disp_dest_pr = '0;
      disp_src1_pr = '0; disp_src2_pr = '0; disp_src1_rdy = '0; disp_src2_rdy = '0;
      disp_payload = '0; cdb_valid = '0; cdb_tag = '0; fu_credit = '0;
   endtask

   task automatic lane(input int i, input bit [1:0] fu, input bit [5:0] s1, input bit r1,
                       input bit [5:0] s2, input bit r2, input bit [63:0] pl);
      disp_valid[i]          = 1'b1;
      disp_fu[2*i +: 2]      = fu;
      disp_dest_pr[i*PW +: PW] = 6'($urandom_range(0, 63));
      disp_src1_pr[i*PW +: PW] = s1;
      disp_src2_pr[i*PW +: PW] = s2;
      disp_src1_rdy[i]       = r1;
      disp_src2_rdy[i]       = r2;
      disp_payload[i*PLW +: PLW] = pl;
   endtask

   task automatic cdb(input int c, input bit [5:0] t);
      cdb_valid[c] = 1'b1;
      cdb_tag[c*PW +: PW] = t;
   endtask

   function automatic bit hit(input bit [5:0] t);
      for (int c = 0; c < CW; c++)
         if (cdb_valid[c] && cdb_tag[c*PW +: PW] == t) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_reset();
      for (int e = 0; e < D; e++) m_v[e] = 1'b0;
   endtask

   // Inputs are already driven; compare this cycle, advance the model, wait for next negedge.
   task automatic step();
      int free, best, e;
      bit [2:0] stall;
      int cred [4];
      bit r1n [D], r2n [D], tk [D];
      int fl [$];
      logic [84:0] exp_f;
      #1;
      free = 0;
      for (int k = 0; k < D; k++) if (!m_v[k]) begin free++; fl.push_back(k); end
      for (int i = 0; i < DW; i++) stall[i] = (free <= i) || flush;
      check("free_count", free_count, free);
      check("disp_stall", disp_stall, stall);
      for (int c = 0; c < 4; c++) cred[c] = int'(fu_credit[2*c +: 2]);
      for (int k = 0; k < D; k++) begin
         r1n[k] = m_r1[k] || hit(m_s1[k]);
         r2n[k] = m_r2[k] || hit(m_s2[k]);
         tk[k]  = 1'b0;
      end
      for (int s = 0; s < IW; s++) begin
         best = -1;
         if (!flush)
            for (int k = 0; k < D; k++)
               if (m_v[k] && r1n[k] && r2n[k] && !tk[k] && cred[m_fu[k]] > 0)
`ifdef RS_AGE_ORDER_EN
                  if (best < 0 || m_seq[k] < m_seq[best]) best = k;
`else
                  if (best < 0) best = k;
`endif
         if (best >= 0) begin
            tk[best] = 1'b1;
            cred[m_fu[best]]--;
            exp_f = {1'b1, m_fu[best], m_d[best], m_s1[best], m_s2[best], m_p[best]};
         end else exp_f = '0;
         check($sformatf("iss_lane%0d", s),
               {iss_valid[s], iss_fu[2*s +: 2], iss_dest_pr[s*PW +: PW], iss_src1_pr[s*PW +: PW],
                iss_src2_pr[s*PW +: PW], iss_payload[s*PLW +: PLW]}, exp_f);
      end
      if (flush) model_reset();
      else begin
         for (int k = 0; k < D; k++) begin
            if (tk[k]) m_v[k] = 1'b0;
            m_r1[k] = r1n[k];
            m_r2[k] = r2n[k];
         end
         for (int i = 0; i < DW; i++) begin
            if (disp_valid[i] && !stall[i]) begin
               e = fl[i];
               m_v[e]  = 1'b1;
               m_fu[e] = disp_fu[2*i +: 2];
               m_d[e]  = disp_dest_pr[i*PW +: PW];
               m_s1[e] = disp_src1_pr[i*PW +: PW];
               m_s2[e] = disp_src2_pr[i*PW +: PW];
               m_p[e]  = disp_payload[i*PLW +: PLW];
               m_r1[e] = disp_src1_rdy[i] || hit(disp_src1_pr[i*PW +: PW]);
               m_r2[e] = disp_src2_rdy[i] || hit(disp_src2_pr[i*PW +: PW]);
               m_seq[e] = seq_ctr++;
            end
         end
      end
      @(negedge clock);
   endtask

   task automatic rand_in();
      int n;
      idle();
      n = $urandom_range(0, 3);
      for (int i = 0; i < n; i++)
         lane(i, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
              6'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), {$urandom, $urandom});
      for (int c = 0; c < CW; c++)
         if ($urandom_range(0, 3) == 0) cdb(c, 6'($urandom_range(0, 15)));
      fu_credit = 8'($urandom);
      flush = ($urandom_range(0, 49) == 0);
   endtask

   initial begin
      bit [63:0] px, py;
      idle();
      #2 reset_n = 1'b0;
      #1;
      check("rst_free", free_count, 16);
      check("rst_iss", iss_valid, 0);
      check("rst_stall", disp_stall, 0);
      model_reset();
      @(negedge clock);
      reset_n = 1'b1;

      // Three ready ALU ops issue together the cycle after dispatch.
      idle(); fu_credit = 8'h03;
      for (int i = 0; i < 3; i++) lane(i, 2'd0, 6'd1, 1, 6'd2, 1, 64'(100 + i));
      step();
      idle(); fu_credit = 8'h03;
      #1 check("r21_iss", iss_valid, 3'b111);
      step();
      idle();
      #1 check("r21_free", free_count, 16);
      step();

      // Fill with src1 waiting on tag 5, then wake everything at once.
      for (int k = 0; k < 6; k++) begin
         idle(); fu_credit = 8'hFF;
         for (int i = 0; i < 3; i++) lane(i, 2'd0, 6'd5, 0, 6'd3, 1, {$urandom, $urandom});
         step();
      end
      idle();
      #1 check("r22_full", free_count, 0);
      check("r22_stall", disp_stall, 3'b111);
      step();
      idle(); cdb(0, 6'd5); fu_credit = 8'h03;
      #1 check("r22_wake_iss", iss_valid, 3'b111);
      step();
      idle(); step();
      idle();
      #1 check("r22_free3", free_count, 3);
      step();
      repeat (8) begin idle(); fu_credit = 8'hFF; step(); end

      // Older MULT at a higher index than a younger MULT, one MULT credit.
      px = 64'hAAAA_0001; py = 64'hBBBB_0002;
      idle(); lane(0, 2'd0, 6'd7, 0, 6'd3, 1, 64'd1); lane(1, 2'd1, 6'd1, 1, 6'd2, 1, px);
      step();
      idle(); cdb(0, 6'd7); fu_credit = 8'h01; step();
      idle(); lane(0, 2'd1, 6'd1, 1, 6'd2, 1, py); step();
      idle(); fu_credit = 8'h04;
      #1 check("r23_iss_a", iss_valid, 3'b001);
`ifdef RS_AGE_ORDER_EN
      check("r23_first", iss_payload[63:0], px);
`else
      check("r23_first", iss_payload[63:0], py);
`endif
      step();
      idle(); fu_credit = 8'h04;
      #1 check("r23_iss_b", iss_valid, 3'b001);
      step();

      // Dispatch-cycle CDB match on src2.
      idle(); lane(0, 2'd0, 6'd1, 1, 6'd9, 0, 64'h99); cdb(0, 6'd9); fu_credit = 8'h03;
      #1 check("r24_same", iss_valid, 3'b000);
      step();
      idle(); fu_credit = 8'h03;
      #1 check("r24_next", iss_valid, 3'b001);
      step();

      // Flush with 8 eligible entries and 2 lanes dispatching.
      for (int k = 0; k < 3; k++) begin
         idle();
         for (int i = 0; i < (k == 2 ? 2 : 3); i++) lane(i, 2'd2, 6'd1, 1, 6'd2, 1, {$urandom, $urandom});
         step();
      end
      idle(); flush = 1; fu_credit = 8'hFF;
      lane(0, 2'd0, 6'd1, 1, 6'd2, 1, 64'd5); lane(1, 2'd0, 6'd1, 1, 6'd2, 1, 64'd6);
      #1 check("r25_iss", iss_valid, 3'b000);
      step();
      idle();
      #1 check("r25_free", free_count, 16);
      step();

      repeat (2000) begin rand_in(); step(); end

      // Asynchronous reset between edges with an issuing entry present.
      idle(); flush = 1; step();
      idle(); lane(0, 2'd0, 6'd1, 1, 6'd2, 1, 64'h77); step();
      idle(); fu_credit = 8'h03;
      #1 check("pre_rst_iss", iss_valid, 3'b001);
      #1 reset_n = 1'b0;
      #1 check("async_rst_iss", iss_valid, 3'b000);
      check("async_rst_free", free_count, 16);
      check("async_rst_stall", disp_stall, 3'b000);
      model_reset();
      @(negedge clock);
      reset_n = 1'b1;
      idle(); step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
